// File: rtl/ps2_byte_collector.sv
// ps2_byte_collector
// Deserialises PS/2 keyboard frames (start, 8 data bits LSB first, odd parity,
// stop) and hands each good byte to the datastore with a one-cycle write strobe
// and an auto-incrementing slot index.
// Optional build macro: PS2_BREAK_FILTER_EN -- when defined, break sequences
// (0xF0 plus the following byte) and 0xE0 prefixes are not written, so only
// make codes reach the datastore.

module ps2_byte_collector #(
   parameter int DEPTH   = 28,
   parameter int TIMEOUT = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       clear,
   output logic [7:0] ps2data_out,
   output logic [4:0] index,
   output logic       write_enable,
   output logic       full,
   output logic       frame_err
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   logic [1:0]      r_clkSync;
   logic [1:0]      r_dataSync;
   logic            r_clkDly;
   state_t          r_state;
   state_t          w_nextState;
   logic [7:0]      r_sr;
   logic [2:0]      r_bitCnt;
   logic            r_parity;
   logic [TO_W-1:0] r_toCnt;
   logic [4:0]      r_wrPtr;

   logic w_fe;
   logic w_bit;
   logic w_timeout;
   logic w_stopFe;
   logic w_good;
   logic w_bad;
   logic w_offer;

   // Two-flop synchronisers on both pins plus a delay flop on the clock path for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clkSync  <= 2'b11;
         r_dataSync <= 2'b11;
         r_clkDly   <= 1'b1;
      end else begin
         r_clkSync  <= {r_clkSync[0], ps2_clk};
         r_dataSync <= {r_dataSync[0], ps2_data};
         r_clkDly   <= r_clkSync[1];
      end
   end

   assign w_fe      = r_clkDly & ~r_clkSync[1];
   assign w_bit     = r_dataSync[1];
   assign w_timeout = (r_toCnt == TO_W'(TIMEOUT));

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: a stalled frame is abandoned, otherwise advance one field per PS/2 falling edge
   always_comb begin
      w_nextState = r_state;
      if (w_timeout) begin
         w_nextState = IDLE;
      end else if (w_fe) begin
         case (r_state)
            IDLE:    if (!w_bit) w_nextState = DATA;
            DATA:    if (r_bitCnt == 3'd7) w_nextState = PARITY;
            PARITY:  w_nextState = STOP;
            STOP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
         endcase
      end
   end

   // Shift register, bit counter and parity capture, all sampled in the falling-edge cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sr     <= 8'h00;
         r_bitCnt <= 3'd0;
         r_parity <= 1'b0;
      end else if (w_fe && !w_timeout) begin
         case (r_state)
            IDLE:    r_bitCnt <= 3'd0;
            DATA: begin
               r_sr     <= {w_bit, r_sr[7:1]};
               r_bitCnt <= r_bitCnt + 3'd1;
            end
            PARITY:  r_parity <= w_bit;
            default: ;
         endcase
      end
   end

   // Stall timer: restarts on every PS/2 edge and only runs while a frame is in progress
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_toCnt <= '0;
      end else if (r_state == IDLE || w_fe) begin
         r_toCnt <= '0;
      end else if (!w_timeout) begin
         r_toCnt <= r_toCnt + 1'b1;
      end
   end

   assign w_stopFe = w_fe && !w_timeout && (r_state == STOP);
   assign w_good   = w_stopFe && w_bit && (^{r_sr, r_parity});
   assign w_bad    = w_stopFe && !w_good;

`ifdef PS2_BREAK_FILTER_EN
   logic r_break;
   logic w_breakNext;

   // Break filter: 0xF0 arms the flag, the byte after it is swallowed, 0xE0 prefixes never pass
   always_comb begin
      w_offer     = 1'b0;
      w_breakNext = r_break;
      if (w_good) begin
         if (r_sr == 8'hF0) begin
            w_breakNext = 1'b1;
         end else if (r_break) begin
            w_breakNext = 1'b0;
         end else if (r_sr != 8'hE0) begin
            w_offer = 1'b1;
         end
      end
   end

   // Break flag register, cleared together with the buffer fill
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_break <= 1'b0;
      end else if (clear) begin
         r_break <= 1'b0;
      end else begin
         r_break <= w_breakNext;
      end
   end
`else
   assign w_offer = w_good;
`endif

   // Accept stage: registered strobe/error, write pointer with saturation at DEPTH, clear has priority
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ps2data_out  <= 8'h00;
         index        <= 5'd0;
         write_enable <= 1'b0;
         full         <= 1'b0;
         frame_err    <= 1'b0;
         r_wrPtr      <= 5'd0;
      end else begin
         write_enable <= 1'b0;
         frame_err    <= w_bad;
         if (clear) begin
            r_wrPtr <= 5'd0;
            full    <= 1'b0;
         end else if (w_offer && !full) begin
            ps2data_out  <= r_sr;
            index        <= r_wrPtr;
            write_enable <= 1'b1;
            r_wrPtr      <= r_wrPtr + 5'd1;
            if (r_wrPtr == 5'(DEPTH - 1)) begin
               full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_byte_collector.sv
// Testbench for ps2_byte_collector: table of single-frame vectors plus
// hand-written sequences for fill/clear, clear collision, timeout and reset.

module tb_ps2_byte_collector;

   localparam int HALF    = 8;
   localparam int DEPTH   = 28;
   localparam int TIMEOUT = 5000;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       clear;
   logic [7:0] ps2data_out;
   logic [4:0] index;
   logic       write_enable;
   logic       full;
   logic       frame_err;

   int checks   = 0;
   int failures = 0;
   int weCount  = 0;
   int errCount = 0;
   logic [7:0] lastData = 8'h00;
   logic [4:0] lastIdx  = 5'd0;

   typedef struct {
      logic [7:0] data;
      logic       doClear;
      logic       parFlip;
      logic       stopFlip;
      logic       expWrite;
      logic [7:0] expData;
      logic [4:0] expIdx;
      logic       expErr;
   } vec_t;

   vec_t vecs[9];

   ps2_byte_collector #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .clear        (clear),
      .ps2data_out  (ps2data_out),
      .index        (index),
      .write_enable (write_enable),
      .full         (full),
      .frame_err    (frame_err)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   // Observe strobes and error pulses away from the active edge
   always @(negedge clk) begin
      if (write_enable) begin
         weCount  = weCount + 1;
         lastData = ps2data_out;
         lastIdx  = index;
      end
      if (frame_err) begin
         errCount = errCount + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Drive the first n bits of an 11-bit frame, LSB (start bit) first
   task automatic sendBits(input logic [10:0] frame, input int n);
      for (int b = 0; b < n; b++) begin
         @(posedge clk); #1;
         ps2_data = frame[b];
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b1;
      end
   endtask

   function automatic logic [10:0] makeFrame(input logic [7:0] data, input logic parFlip, input logic stopFlip);
      return {~stopFlip, (~^data) ^ parFlip, data, 1'b0};
   endfunction

   task automatic applyStimulus(input logic [7:0] data, input logic parFlip, input logic stopFlip);
      sendBits(makeFrame(data, parFlip, stopFlip), 11);
      repeat (10) @(posedge clk);
   endtask

   task automatic pulseClear();
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // Main sequence
   initial begin
      int we0;
      int e0;

      // Single-frame vectors; indices depend on the preceding entries
      vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 5'd0, 1'b0};
      vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1};
      vecs[2] = '{8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h32, 5'd1, 1'b0};
      vecs[3] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h1C, 5'd0, 1'b0};
`ifdef PS2_BREAK_FILTER_EN
      vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
      vecs[5] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
      vecs[6] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
      vecs[7] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
      vecs[8] = '{8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2B, 5'd1, 1'b0};
`else
      vecs[4] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 5'd1, 1'b0};
      vecs[5] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1C, 5'd2, 1'b0};
      vecs[6] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hE0, 5'd3, 1'b0};
      vecs[7] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1};
      vecs[8] = '{8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2B, 5'd4, 1'b0};
`endif

      reset    = 1'b0;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      clear    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_data", {24'h0, ps2data_out}, 32'h00);
      checkOutput("rst_index", {27'h0, index}, 32'h0);
      checkOutput("rst_we", {31'h0, write_enable}, 32'h0);
      checkOutput("rst_full", {31'h0, full}, 32'h0);
      checkOutput("rst_err", {31'h0, frame_err}, 32'h0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (5) @(posedge clk);

      // Table-driven single frames
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].doClear) pulseClear();
         we0 = weCount;
         e0  = errCount;
         applyStimulus(vecs[i].data, vecs[i].parFlip, vecs[i].stopFlip);
         checkOutput($sformatf("vec%0d_writes", i), 32'(weCount - we0), {31'h0, vecs[i].expWrite});
         checkOutput($sformatf("vec%0d_errs", i), 32'(errCount - e0), {31'h0, vecs[i].expErr});
         if (vecs[i].expWrite) begin
            checkOutput($sformatf("vec%0d_data", i), {24'h0, lastData}, {24'h0, vecs[i].expData});
            checkOutput($sformatf("vec%0d_index", i), {27'h0, lastIdx}, {27'h0, vecs[i].expIdx});
         end
      end

      // Fill to DEPTH, then one more byte that must be dropped
      pulseClear();
      checkOutput("fill_start_full", {31'h0, full}, 32'h0);
      for (int i = 0; i <= DEPTH; i++) begin
         logic [7:0] d;
         d   = 8'h40 + 8'(i);
         we0 = weCount;
         e0  = errCount;
         applyStimulus(d, 1'b0, 1'b0);
         if (i < DEPTH) begin
            checkOutput($sformatf("fill%0d_writes", i), 32'(weCount - we0), 32'd1);
            checkOutput($sformatf("fill%0d_index", i), {27'h0, lastIdx}, 32'(i));
            checkOutput($sformatf("fill%0d_data", i), {24'h0, lastData}, {24'h0, d});
            checkOutput($sformatf("fill%0d_full", i), {31'h0, full}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
         end else begin
            checkOutput("overflow_writes", 32'(weCount - we0), 32'd0);
            checkOutput("overflow_errs", 32'(errCount - e0), 32'd0);
            checkOutput("overflow_full", {31'h0, full}, 32'd1);
            checkOutput("overflow_index", {27'h0, index}, 32'd27);
         end
      end
      pulseClear();
      checkOutput("clear_full", {31'h0, full}, 32'h0);
      we0 = weCount;
      applyStimulus(8'h2B, 1'b0, 1'b0);
      checkOutput("after_clear_writes", 32'(weCount - we0), 32'd1);
      checkOutput("after_clear_index", {27'h0, lastIdx}, 32'd0);
      checkOutput("after_clear_data", {24'h0, lastData}, 32'h2B);

      // Clear held across the stop bit: the good frame is dropped and the pointer restarts
      we0 = weCount;
      e0  = errCount;
      sendBits(makeFrame(8'h35, 1'b0, 1'b0), 10);
      #1 clear = 1'b1;
      sendBits({10'h0, 1'b1}, 1);
      repeat (10) @(posedge clk);
      #1 clear = 1'b0;
      checkOutput("clear_collide_writes", 32'(weCount - we0), 32'd0);
      checkOutput("clear_collide_errs", 32'(errCount - e0), 32'd0);
      we0 = weCount;
      applyStimulus(8'h1C, 1'b0, 1'b0);
      checkOutput("post_collide_writes", 32'(weCount - we0), 32'd1);
      checkOutput("post_collide_index", {27'h0, lastIdx}, 32'd0);

      // Stalled partial frame is discarded silently, next frame is clean
      we0 = weCount;
      e0  = errCount;
      sendBits(makeFrame(8'h55, 1'b0, 1'b0), 5);
      repeat (TIMEOUT + 10) @(posedge clk);
      applyStimulus(8'h32, 1'b0, 1'b0);
      checkOutput("timeout_writes", 32'(weCount - we0), 32'd1);
      checkOutput("timeout_data", {24'h0, lastData}, 32'h32);
      checkOutput("timeout_index", {27'h0, lastIdx}, 32'd1);
      checkOutput("timeout_errs", 32'(errCount - e0), 32'd0);

      // Reset in the middle of a frame
      sendBits(makeFrame(8'h1C, 1'b0, 1'b0), 5);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("midrst_data", {24'h0, ps2data_out}, 32'h00);
      checkOutput("midrst_index", {27'h0, index}, 32'h0);
      checkOutput("midrst_we", {31'h0, write_enable}, 32'h0);
      checkOutput("midrst_full", {31'h0, full}, 32'h0);
      checkOutput("midrst_err", {31'h0, frame_err}, 32'h0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (5) @(posedge clk);
      we0 = weCount;
      e0  = errCount;
      applyStimulus(8'h1C, 1'b0, 1'b0);
      checkOutput("postrst_writes", 32'(weCount - we0), 32'd1);
      checkOutput("postrst_data", {24'h0, lastData}, 32'h1C);
      checkOutput("postrst_index", {27'h0, lastIdx}, 32'd0);
      checkOutput("postrst_errs", 32'(errCount - e0), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_byte_collector.md
# ps2_byte_collector

Upstream feeder for the datastore register. Deserialises PS/2 keyboard frames (start, 8 data bits LSB first, odd parity, stop), validates them and presents each accepted byte with a one-cycle write strobe and an auto-incrementing byte index. Its outputs `ps2data_out`, `index` and `write_enable` connect directly to the datastore's `ps2data_in`, `index` and `write_enable` inputs. The datastore fills a 224-bit (28-byte) message buffer for the A5/1 encrypt/decrypt path.

## Interface
- `DEPTH`, 28: bytes accepted before `full`; the index runs 0..DEPTH-1.
- `TIMEOUT`, 5000: `clk` cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned.
- `clk` in 1: system clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `clear` in 1: synchronous; restarts buffer fill.
- `ps2data_out` out 8: last accepted byte.
- `index` out 5: buffer slot for `ps2data_out`.
- `write_enable` out 1: one-cycle strobe, byte valid.
- `full` out 1: DEPTH bytes written, further bytes dropped.
- `frame_err` out 1: one-cycle pulse on parity or stop-bit error.

## Operation
- **Synchronisers:** `ps2_clk` and `ps2_data` each pass through 2 flops. A third flop on the clock path detects a falling edge; `fe` is high for one `clk` cycle per edge. Data is sampled from the synchronised `ps2_data` in the `fe` cycle.
- **FSM:**
  - IDLE: on `fe` with data=0, go to DATA with bit count 0. On `fe` with data=1 (bad start), stay in IDLE.
  - DATA: on each `fe`, shift `{bit, sr[7:1]}` and increment the count. After the 8th bit, go to PARITY.
  - PARITY: on `fe`, latch the parity bit and go to STOP.
  - STOP: on `fe`, the frame is good if stop=1 and XOR(sr, parity)=1. Go to IDLE in either case.
  - A bad frame pulses `frame_err` for one cycle, with no write.
- **Timeout:** a counter clears on every `fe` and counts only while not in IDLE. When it reaches TIMEOUT, the FSM forces IDLE and the partial frame is discarded silently (no `frame_err`).
- **Accept stage:** a good frame is offered to the write logic as byte `b`. If it is accepted, `ps2data_out`=b, `index`=wr_ptr and `write_enable`=1 for exactly one cycle. wr_ptr increments by 1 in the same update.
  - When wr_ptr becomes DEPTH, `full`=1 and wr_ptr holds at DEPTH.
  - `index` holds its last written value and never shows DEPTH.
  - While `full`=1, good bytes are dropped: no strobe, no error.
- **Clear:** `clear`=1 sets wr_ptr=0 and `full`=0, and suppresses any strobe in that cycle. Clear wins over a simultaneous good frame, which is dropped. The FSM is unaffected.
- **Reset values:** `ps2data_out`=0x00, `index`=0, `write_enable`=0, `full`=0, `frame_err`=0, FSM in IDLE, wr_ptr=0, timeout counter=0, break flag=0.
- **Reset mid-frame:** the partial frame is lost, and the next start bit begins a fresh frame.

## Timing
- `fe` occurs 3 `clk` cycles after a `ps2_clk` fall at the pin (2 synchroniser flops plus the edge flop).
- `write_enable` or `frame_err` is registered and asserts in the cycle after the `fe` of the stop bit. Good frames therefore strobe exactly once, 1 cycle after the stop-bit `fe`.
- `ps2data_out` and `index` are valid in the strobe cycle and hold until the next accepted byte.
- Back-to-back frames need no gap: PS/2 bit periods (≥30 µs) far exceed the 1-cycle accept latency.
- `ps2_clk` low/high phases must each be at least 3 `clk` periods, or edges are missed.

## Configuration
- `PS2_BREAK_FILTER_EN` defined: only make codes reach the datastore.
  - Byte 0xF0 sets the break flag and is not written.
  - The next good byte clears the flag and is not written.
  - Byte 0xE0 is never written.
  - `clear` and reset both clear the break flag.
- `PS2_BREAK_FILTER_EN` undefined: every good byte, including 0xF0 and 0xE0, is written in order.

## Test plan
- **Single make code:** after reset, send frame 0x1C with parity 0 → one `write_enable` pulse with `ps2data_out`=0x1C, `index`=0; `frame_err`=0.
- **Bad parity:** send 0x1C with parity 1 → `frame_err` pulses once, no `write_enable`. The next good frame 0x32 is written at `index`=0.
- **Break filter:** send 0x1C, 0xF0, 0x1C.
  - With `PS2_BREAK_FILTER_EN`: one write, (0x1C, idx 0).
  - Without it: writes (0x1C, 0), (0xF0, 1), (0x1C, 2).
- **Fill and clear:** send 29 distinct good bytes → writes at indices 0..27, `full`=1 after the 28th, and the 29th is dropped. Pulse `clear`, then send 0x2B → `full`=0 and write at `index`=0.
- **Timeout:** send a start bit plus 4 data bits, then idle for TIMEOUT+10 cycles, then a full frame 0x32 → exactly one write of 0x32 and no `frame_err`.
- **Reset mid-frame:** assert `reset` low after 5 bits of a frame → all outputs go to their reset values immediately. After release, frame 0x1C is written at `index`=0.
